// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: 2-bit counters, tags and targets, plus branch/mispredict stats.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor #(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRIES   = 64,
  parameter int GHR_WIDTH = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PC_WIDTH-1:0]  lookup_pc_i,
  output logic                 predict_taken_o,
  output logic [PC_WIDTH-1:0]  predict_pc_next_o,
  input  logic                 update_en_i,
  input  logic [PC_WIDTH-1:0]  update_pc_i,
  input  logic                 update_taken_i,
  input  logic [PC_WIDTH-1:0]  update_target_i,
  input  logic                 update_mispredicted_i,
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  output logic [GHR_WIDTH-1:0] lookup_ghr_o,
  input  logic [GHR_WIDTH-1:0] update_ghr_i,
`endif
  output logic [CNT_WIDTH-1:0] branch_count_o,
  output logic [CNT_WIDTH-1:0] mispredict_count_o
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_W    = PC_WIDTH - IDX_BITS - 2;

  logic [ENTRIES-1:0]               valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]          ctr_q, ctr_d;
  logic [ENTRIES-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [ENTRIES-1:0][PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_WIDTH-1:0]             br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0]             mis_cnt_q, mis_cnt_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, up_hit;

  // Byte offset bits never take part in indexing or tagging.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  assign lookup_ghr_o = ghr_q;
  assign lk_idx = lookup_pc_i[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign up_idx = update_pc_i[IDX_BITS+1:2] ^ IDX_BITS'(update_ghr_i);

  // Casting {ghr, taken} down to GHR_WIDTH drops the oldest bit; also covers GHR_WIDTH=1.
  always_comb begin
    ghr_d = ghr_q;
    if (update_en_i) ghr_d = GHR_WIDTH'({ghr_q, update_taken_i});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign lk_idx = lookup_pc_i[IDX_BITS+1:2];
  assign up_idx = update_pc_i[IDX_BITS+1:2];
`endif

  assign lk_tag = lookup_pc_i[PC_WIDTH-1:IDX_BITS+2];
  assign up_tag = update_pc_i[PC_WIDTH-1:IDX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads registered state only: a same-cycle update becomes visible next cycle.
  assign predict_taken_o   = lk_hit && ctr_q[lk_idx][1];
  assign predict_pc_next_o = predict_taken_o ? tgt_q[lk_idx] : lookup_pc_i + PC_WIDTH'(4);

  assign branch_count_o     = br_cnt_q;
  assign mispredict_count_o = mis_cnt_q;

  always_comb begin
    valid_d   = valid_q;
    ctr_d     = ctr_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (update_en_i) begin
      br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
      if (update_mispredicted_i) mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
      if (up_hit) begin
        if (update_taken_i) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
          tgt_d[up_idx] = update_target_i;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (update_taken_i) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = update_target_i;
        ctr_d[up_idx]   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      ctr_q     <= {ENTRIES{2'b01}};
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctr_q     <= ctr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  // Tags and targets are meaningless while valid is clear, so they carry no reset.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed check of branch_predictor against a behavioural table model.
module tb_branch_predictor;
  localparam int PW = 32, N = 64, IB = 6, GW = 6, CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [PW-1:0] lookup_pc, update_pc, update_target, predict_pc_next;
  logic          predict_taken, update_en, update_taken, update_mis;
  logic [CW-1:0] branch_count, mispredict_count;
  logic [GW-1:0] update_ghr;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GW-1:0] lookup_ghr;
`endif

  branch_predictor #(.PC_WIDTH(PW), .ENTRIES(N), .GHR_WIDTH(GW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_pc_i(lookup_pc), .predict_taken_o(predict_taken), .predict_pc_next_o(predict_pc_next),
    .update_en_i(update_en), .update_pc_i(update_pc), .update_taken_i(update_taken),
    .update_target_i(update_target), .update_mispredicted_i(update_mis),
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    .lookup_ghr_o(lookup_ghr), .update_ghr_i(update_ghr),
`endif
    .branch_count_o(branch_count), .mispredict_count_o(mispredict_count));

  int n_tests = 0, n_fail = 0;
  bit chk_on = 0;

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", t, obs, exp);
    end
  endtask

  // Reference model: one record per table slot, counters as plain integers 0..3.
  bit            m_valid [N];
  int            m_ctr   [N];
  longint        m_tag   [N];
  logic [PW-1:0] m_tgt   [N];
  longint        m_br, m_mis;
  int            m_ghr;

  function automatic int m_index(input logic [PW-1:0] pc, input int g);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return ((int'(pc) >>> 2) ^ g) & (N - 1);
`else
    return (int'(pc) >>> 2) & (N - 1) + 0 * g;
`endif
  endfunction

  function automatic longint m_tagof(input logic [PW-1:0] pc);
    return longint'(pc) / (4 * N);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
    m_br = 0; m_mis = 0; m_ghr = 0;
  endtask

  task automatic m_update(input logic [PW-1:0] pc, input bit tk, input logic [PW-1:0] tgt,
                          input bit mis, input int g);
    int i;
    i = m_index(pc, g);
    m_br = (m_br + 1) % (64'd1 << CW);
    if (mis) m_mis = (m_mis + 1) % (64'd1 << CW);
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
    end
    m_ghr = ((m_ghr * 2) + int'(tk)) % (1 << GW);
  endtask

  // Drives one cycle: outputs are checked against the model mid-cycle, then the model advances at the edge.
  task automatic step(input logic [PW-1:0] lpc, input bit en, input logic [PW-1:0] upc,
                      input bit tk, input logic [PW-1:0] tgt, input bit mis, input int ug);
    int i;
    bit e_tk;
    logic [PW-1:0] e_nxt;
    lookup_pc = lpc; update_en = en; update_pc = upc; update_taken = tk;
    update_target = tgt; update_mis = mis; update_ghr = GW'(ug);
    @(negedge clk);
    if (chk_on) begin
      i = m_index(lpc, m_ghr);
      e_tk  = m_valid[i] && m_tag[i] == m_tagof(lpc) && m_ctr[i] >= 2;
      e_nxt = e_tk ? m_tgt[i] : lpc + 32'd4;
      chk("pred_taken", 64'(predict_taken), 64'(e_tk));
      chk("pred_next", 64'(predict_pc_next), 64'(e_nxt));
      chk("branch_cnt", 64'(branch_count), 64'(m_br));
      chk("mispred_cnt", 64'(mispredict_count), 64'(m_mis));
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      chk("ghr", 64'(lookup_ghr), 64'(m_ghr));
`endif
    end
    @(posedge clk);
    if (rst) m_reset();
    else if (en) m_update(upc, tk, tgt, mis, ug);
    #1;
  endtask

  task automatic upd(input logic [PW-1:0] pc, input bit tk, input logic [PW-1:0] tgt);
    step(pc, 1'b1, pc, tk, tgt, 1'b0, m_ghr);
  endtask

  task automatic idle(input logic [PW-1:0] lpc);
    step(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(32'h100); rst = 1'b0;
  endtask

  // Checks the combinational lookup against fixed values without advancing the clock.
  task automatic expect_pred(input string t, input logic [PW-1:0] lpc, input bit tk,
                             input logic [PW-1:0] nxt);
    lookup_pc = lpc; update_en = 1'b0; #1;
    chk({t, "_tk"}, 64'(predict_taken), 64'(tk));
    chk({t, "_nxt"}, 64'(predict_pc_next), 64'(nxt));
  endtask

  initial begin
    logic [PW-1:0] pc, pc2;
    rst = 1'b1;
    lookup_pc = '0; update_en = 0; update_pc = '0; update_taken = 0;
    update_target = '0; update_mis = 0; update_ghr = '0;
    @(posedge clk); #1;
    idle(32'h0);
    rst = 1'b0;
    m_reset();
    chk_on = 1;

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    expect_pred("t1", 32'h100, 1'b0, 32'h104);
    chk("t1_br", 64'(branch_count), 64'd0);
    chk("t1_mis", 64'(mispredict_count), 64'd0);

    upd(32'h100, 1'b1, 32'h80);
    expect_pred("t2_alloc", 32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    expect_pred("t2_ctr00", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80);
    expect_pred("t2_ctr01", 32'h100, 1'b0, 32'h104);

    for (int k = 0; k < 5; k++) upd(32'h40, 1'b1, 32'h10);
    upd(32'h40, 1'b0, 32'h0);
    expect_pred("t3_sat", 32'h40, 1'b1, 32'h10);

    do_reset();
    upd(32'h100, 1'b1, 32'h80);
    expect_pred("t4_alias", 32'h200, 1'b0, 32'h204);
    upd(32'h200, 1'b1, 32'h300);
    expect_pred("t4_new", 32'h200, 1'b1, 32'h300);
    expect_pred("t4_old", 32'h100, 1'b0, 32'h104);

    do_reset();
    lookup_pc = 32'h100; update_en = 1; update_pc = 32'h100; update_taken = 1;
    update_target = 32'h80; update_mis = 0; #1;
    chk("t5_same_tk", 64'(predict_taken), 64'd0);
    chk("t5_same_nxt", 64'(predict_pc_next), 64'h104);
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 0);
    expect_pred("t5_next", 32'h100, 1'b1, 32'h80);

    do_reset();
    step(32'h0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 0);
    step(32'h0, 1'b1, 32'h14, 1'b0, 32'h20, 1'b1, 0);
    step(32'h0, 1'b1, 32'h18, 1'b1, 32'h20, 1'b0, 0);
    step(32'h0, 1'b0, 32'h18, 1'b1, 32'h20, 1'b1, 0);
    chk("t6_br", 64'(branch_count), 64'd3);
    chk("t6_mis", 64'(mispredict_count), 64'd1);
    do_reset();
    chk("t6_rst_br", 64'(branch_count), 64'd0);
    chk("t6_rst_mis", 64'(mispredict_count), 64'd0);
    expect_pred("t6_rst", 32'h100, 1'b0, 32'h104);
`else
    upd(32'h100, 1'b1, 32'h80);
    upd(32'h104, 1'b1, 32'h80);
    upd(32'h108, 1'b0, 32'h0);
    lookup_pc = 32'h0; #1;
    chk("t6_ghr", 64'(lookup_ghr), 64'b000110);
    do_reset();
    chk("t6_ghr_rst", 64'(lookup_ghr), 64'd0);
`endif

    // Random traffic over a few tags per index so hits, aliasing and saturation all occur.
    for (int k = 0; k < 3000; k++) begin
      pc  = (PW'($urandom_range(0, 3)) << (IB + 2)) | (PW'($urandom_range(0, N - 1)) << 2)
            | PW'($urandom_range(0, 3));
      pc2 = ($urandom_range(0, 3) == 0) ? pc :
            (PW'($urandom_range(0, 3)) << (IB + 2)) | (PW'($urandom_range(0, N - 1)) << 2);
      if (k % 16 == 0) pc = 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 199) == 0);
      step(pc, $urandom_range(0, 3) != 0, pc2, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? m_ghr : int'($urandom_range(0, 63)));
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the fetch stage of the pipelined core. It replaces the fixed "predict not-taken, resolve later" behaviour of the current fetch path.
- Holds a direct-mapped table of entries. Each entry has a valid bit, a tag, a branch target and a 2-bit saturating counter.
- Fetch looks the table up combinationally with the current PC. Execute trains the table one update per cycle.
- Also keeps branch and mispredict statistics counters for performance tests.

Parameters:
- PC_WIDTH, 32: width of PC and target fields.
- ENTRIES, 64: table depth; power of two, >= 2. IDX_BITS = log2(ENTRIES).
- GHR_WIDTH, 6: global history length; used only with GSHARE_EN; must be 1..IDX_BITS.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- lookup_pc_i  in  PC_WIDTH  PC being fetched (pcF).
- predict_taken_o  out  1  lookup predicts taken.
- predict_pc_next_o  out  PC_WIDTH  predicted next PC: target if taken, else lookup_pc_i+4.
- update_en_i  in  1  a resolved branch/jump is presented this cycle.
- update_pc_i  in  PC_WIDTH  PC of the resolved instruction (pcE).
- update_taken_i  in  1  actual outcome.
- update_target_i  in  PC_WIDTH  actual target (pcTarget).
- update_mispredicted_i  in  1  execute detected a misprediction (drives flush elsewhere).
- branch_count_o  out  CNT_WIDTH  number of accepted updates.
- mispredict_count_o  out  CNT_WIDTH  number of updates with update_mispredicted_i=1.

Interface decision: one clock (clk_i); reset rst_i is synchronous and active-high.

Behaviour:

Address mapping:
- index = pc[IDX_BITS+1:2]
- tag = pc[PC_WIDTH-1:IDX_BITS+2]
- pc[1:0] is ignored.

Lookup (combinational, zero latency):
- hit = valid[index] && tag[index]==lookup tag.
- predict_taken_o = hit && counter[index][1].
- predict_pc_next_o = predict_taken_o ? target[index] : lookup_pc_i + 4, computed modulo 2^PC_WIDTH.

Update (takes effect at the clock edge when update_en_i=1):
- Tag hit, counter: taken -> increment, saturating at 2'b11; not-taken -> decrement, saturating at 2'b00.
- Tag hit, target: if taken, the target is overwritten with update_target_i.
- Miss and taken: allocate or replace the entry. Set valid=1, write the new tag and update_target_i, counter=2'b10 (weakly taken).
- Miss and not-taken: no table change.

Same-index lookup and update in the same cycle:
- Lookup returns the pre-update contents; there is no bypass.
- The new value is visible from the next cycle.

Statistics:
- branch_count_o increments on every update_en_i.
- mispredict_count_o increments when update_en_i && update_mispredicted_i.
- update_mispredicted_i is ignored when update_en_i=0.
- Both counters wrap modulo 2^CNT_WIDTH.

Reset (rst_i=1 at an edge):
- Every valid bit is cleared. Every counter is set to 2'b01. Targets and tags are don't-care.
- Both statistics counters go to 0. GHR goes to 0 if present.
- Reset overrides any same-cycle update.
- Outputs after reset: predict_taken_o=0, predict_pc_next_o=lookup_pc_i+4, both counters 0.
- Reset asserted in the middle of a program returns the block to this state on the next edge.

Optional Feature:
Macro BRANCH_PREDICTOR_GSHARE_EN.

Defined:
- Adds a GHR_WIDTH global history register and two ports:
  - lookup_ghr_o  out  GHR_WIDTH: current GHR.
  - update_ghr_i  in  GHR_WIDTH: the GHR captured at lookup and carried down the pipeline.
- Lookup index = pc[IDX_BITS+1:2] XOR zero-extended GHR.
- Update index = update pc bits XOR zero-extended update_ghr_i. The tag is unchanged.
- On update_en_i the GHR shifts: ghr <= {ghr[GHR_WIDTH-2:0], update_taken_i}. For GHR_WIDTH=1, ghr <= update_taken_i.

Undefined:
- No GHR and no extra ports; indexing is purely PC-based as above.

Test Plan (ENTRIES=64, macro undefined unless noted):
1. Reset, then lookup 0x100 -> predict_taken_o=0, predict_pc_next_o=0x104, both counters=0.
2. Update pc=0x100 taken, target=0x80 -> next cycle lookup 0x100 gives taken=1, next=0x80. Two not-taken updates -> counter 00, not taken, next=0x104. One taken update -> counter 01, still not taken.
3. Saturation: 5 taken updates on 0x40 (target 0x10) -> counter 11. One not-taken -> 10, still predicts taken, next=0x10.
4. Alias: train 0x100 taken (target 0x80). Lookup 0x200 (same index 0, different tag) -> not taken, next=0x204. Taken update 0x200 target 0x300 -> lookup 0x200 gives 0x300; lookup 0x100 now misses.
5. Same-cycle lookup and update of 0x100 from reset state (taken, target 0x80) -> that cycle predicts not taken/0x104; next cycle predicts taken/0x80.
6. Stats: 3 updates, one with update_mispredicted_i=1, plus one cycle with update_en_i=0 and update_mispredicted_i=1 -> branch_count_o=3, mispredict_count_o=1. Then rst_i for one cycle -> counters 0 and lookup 0x100 not taken. With BRANCH_PREDICTOR_GSHARE_EN: taken, taken, not-taken updates -> lookup_ghr_o=6'b000110.
